i2s_dac_tx: RTL

//  Serialises 24-bit audio samples into an I2S stream (BCLK, LRCK, DACDAT) for the audio DAC.

---
 rtl/i2s_dac_tx_if.sv | 29 ++
 rtl/i2s_dac_tx.sv | 126 ++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx_if.sv
// ----------------------------------------------------------------------------
// i2s_dac_tx_if
// Sample hand-off between the upstream sample generator and the I2S DAC
// transmitter. A word moves on any clk_fast edge where data_valid and
// data_ready are both high.
//   data        WIDTH  sample word, MSB first on the wire
//   data_valid  1      data holds a sample this cycle
//   data_ready  1      transmitter holding register is empty
// master: sample generator side, slave: transmitter side.
// ----------------------------------------------------------------------------
interface i2s_dac_tx_if #(
   parameter int WIDTH = 24
);
   logic [WIDTH-1:0] data;
   logic             data_valid;
   logic             data_ready;

   modport master (
      output data,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/i2s_dac_tx.sv
// ----------------------------------------------------------------------------
// i2s_dac_tx
// Serialises WIDTH-bit samples into an I2S stream. Each accepted sample is
// played on both the left and right slot of one frame. BCLK and LRCK are
// derived from clk_fast. A one-word holding register decouples the upstream
// handshake from the frame timing. When no new word has arrived by the start
// of a frame, the previous frame is repeated and underrun pulses.
// Ports:
//   clk_fast     in   only clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   up           slave sample handshake (data, data_valid, data_ready)
//   bclk         out  I2S bit clock, half-period BCLK_DIV clk_fast cycles
//   lrck         out  word select, 0 = left slot, 1 = right slot
//   dacdat       out  serial data, updated on BCLK falling edges only
//   frame_start  out  one-cycle pulse when a new frame is loaded
//   underrun     out  one-cycle pulse when a frame loads without a new word
// ----------------------------------------------------------------------------
module i2s_dac_tx #(
   parameter int WIDTH    = 24,
   parameter int SLOT     = 32,
   parameter int BCLK_DIV = 4
) (
   input  logic        clk_fast,
   input  logic        rst_n,
   i2s_dac_tx_if.slave up,
   output logic        bclk,
   output logic        lrck,
   output logic        dacdat,
   output logic        frame_start,
   output logic        underrun
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int CNT_W = $clog2(2 * SLOT);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             bclk_q, bclk_d;
   logic             lrck_q, lrck_d;
   logic             dacdat_q, dacdat_d;
   logic [WIDTH-1:0] frame_q, frame_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             frame_start_q, frame_start_d;
   logic             underrun_q, underrun_d;

   logic             div_tick;
   logic             fall_evt;
   logic             load_evt;
   logic             xfer;
   logic [CNT_W-1:0] pos;
   logic [IDX_W-1:0] idx;

   always_comb begin
      div_tick  = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
      div_cnt_d = div_tick ? '0 : div_cnt_q + 1'b1;
      bclk_d    = bclk_q ^ div_tick;
      // A toggle while bclk is high is a BCLK falling edge.
      fall_evt  = div_tick & bclk_q;

      bit_cnt_d = bit_cnt_q;
      if (fall_evt) begin
         bit_cnt_d = (bit_cnt_q == CNT_W'(2 * SLOT - 1)) ? '0 : bit_cnt_q + 1'b1;
      end
      load_evt = fall_evt && (bit_cnt_d == '0);

      // Position inside the current slot; position 0 is the I2S delay bit,
      // positions 1..WIDTH carry the word MSB first, the rest pad with zero.
      pos = (bit_cnt_d >= CNT_W'(SLOT)) ? bit_cnt_d - CNT_W'(SLOT) : bit_cnt_d;
      idx = IDX_W'(CNT_W'(WIDTH) - pos);

      lrck_d   = lrck_q;
      dacdat_d = dacdat_q;
      if (fall_evt) begin
         lrck_d   = (bit_cnt_d >= CNT_W'(SLOT));
         dacdat_d = 1'b0;
         if ((pos != '0) && (pos <= CNT_W'(WIDTH))) begin
            dacdat_d = frame_q[idx];
         end
      end

      // Transfer and frame load can coincide only while holding is empty:
      // the load then repeats the old frame and the new word stays held.
      xfer          = up.data_valid & ~hold_full_q;
      frame_d       = (load_evt && hold_full_q) ? hold_q : frame_q;
      hold_d        = xfer ? up.data : hold_q;
      hold_full_d   = xfer ? 1'b1 : (load_evt ? 1'b0 : hold_full_q);
      frame_start_d = load_evt;
      underrun_d    = load_evt & ~hold_full_q;
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         bclk_q        <= 1'b0;
         lrck_q        <= 1'b0;
         dacdat_q      <= 1'b0;
         frame_q       <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         bclk_q        <= bclk_d;
         lrck_q        <= lrck_d;
         dacdat_q      <= dacdat_d;
         frame_q       <= frame_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign up.data_ready = ~hold_full_q;
   assign bclk          = bclk_q;
   assign lrck          = lrck_q;
   assign dacdat        = dacdat_q;
   assign frame_start   = frame_start_q;
   assign underrun      = underrun_q;

endmodule
